// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_pkg
//  Description : Shared types and defaults for the GCD host sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package gcd_pkg;

  // Default operand/result width, matching the GCD datapath bus
  localparam int GCD_W       = 16;
  // Default number of WAIT cycles before a hung unit is abandoned
  localparam int GCD_TIMEOUT = 1023;

  // Host sequencer states, in the order a unit job walks through them
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LDA   = 3'd2,
    ST_LDB   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_RESP  = 3'd5,
    ST_CLR   = 3'd6
  } gcd_host_state_t;

endpackage : gcd_pkg
`default_nettype wire

// File: rtl/gcd_timeout_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_timeout_ctr
//  Description : Clear/enable up-counter with a terminal-count flag that fires
//                when the count reaches TIMEOUT-1.
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_timeout_ctr
  import gcd_pkg::*;
#(
  parameter int TIMEOUT = GCD_TIMEOUT,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CW-1:0] c_TC  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] c_ONE = CW'(1);

  logic [CW-1:0] r_count;

  // Count while enabled; clear has priority so a new wait always starts at 0
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign o_tc = (r_count == c_TC);

endmodule : gcd_timeout_ctr
`default_nettype wire

// File: rtl/gcd_host.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_host
//  Description : Host-side sequencer for the GCD datapath/controller pair.
//                Takes operand pairs on a valid/ready channel, feeds the unit
//                start/A/B serially, waits for done (with timeout), returns
//                the result on a second valid/ready channel and clears the
//                unit between jobs. Zero operands are answered locally.
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_host
  import gcd_pkg::*;
#(
  parameter int WIDTH   = GCD_W,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  // upstream request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  // GCD unit pins
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  output logic             gcd_rst,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result,
  // downstream response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_gcd,
  output logic             rsp_err
);

  localparam int c_CW = $clog2(TIMEOUT + 1);

  gcd_host_state_t  r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rsp_gcd;
  logic             r_rsp_err;
  logic             r_bypass;   // current job was answered without the unit

  logic             w_tc;
  logic             w_ctr_clr;
  logic             w_ctr_en;

  // The wait budget restarts as B is loaded and runs only while waiting
  assign w_ctr_clr = (r_state == ST_LDB);
  assign w_ctr_en  = (r_state == ST_WAIT);

  gcd_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CW      (c_CW)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_ctr_clr),
    .i_en  (w_ctr_en),
    .o_tc  (w_tc)
  );

  // Sequencer FSM together with operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_rsp_gcd <= '0;
      r_rsp_err <= 1'b0;
      r_bypass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_a <= req_a;
            r_b <= req_b;
            if ((req_a != '0) && (req_b != '0)) begin
              r_bypass <= 1'b0;
              r_state  <= ST_START;
            end else begin
              // gcd(0,x) = x and gcd(0,0) = 0, so a|b is the answer
              r_bypass  <= 1'b1;
              r_rsp_gcd <= req_a | req_b;
              r_rsp_err <= 1'b0;
              r_state   <= ST_RESP;
            end
          end
        end
        ST_START: r_state <= ST_LDA;
        ST_LDA:   r_state <= ST_LDB;
        ST_LDB:   r_state <= ST_WAIT;
        ST_WAIT: begin
          // done takes priority over a timeout in the same cycle
          if (gcd_done) begin
            r_rsp_gcd <= gcd_result;
            r_rsp_err <= 1'b0;
            r_state   <= ST_RESP;
          end else if (w_tc) begin
            r_rsp_gcd <= '0;
            r_rsp_err <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= r_bypass ? ST_IDLE : ST_CLR;
          end
        end
        ST_CLR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Serial data bus: 0 with start, then A, then B, otherwise idle at 0
  always_comb begin
    gcd_data = '0;
    case (r_state)
      ST_LDA:  gcd_data = r_a;
      ST_LDB:  gcd_data = r_b;
      default: gcd_data = '0;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign gcd_start = (r_state == ST_START);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_gcd   = r_rsp_gcd;
  assign rsp_err   = r_rsp_err;
  // The unit is cleared after every unit job and whenever the host resets
  assign gcd_rst   = rst | (r_state == ST_CLR);

endmodule : gcd_host
`default_nettype wire

// File: tb/tb_gcd_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_host
//  Description : Self-checking bench for gcd_host with a behavioural GCD unit
//                (Euclid, one remainder step per cycle) or a timed stub.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gcd_host;

  localparam int c_W  = 16;
  localparam int c_TO = 8;
  localparam logic [c_W-1:0] c_STUB_RES = 16'hA5C3;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [c_W-1:0] req_a;
  logic [c_W-1:0] req_b;
  logic           gcd_start;
  logic [c_W-1:0] gcd_data;
  logic           gcd_rst;
  logic           gcd_done;
  logic [c_W-1:0] gcd_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [c_W-1:0] rsp_gcd;
  logic           rsp_err;

  int n_vec = 0;
  int n_err = 0;

  // unit model control: mode 0 = real Euclid, 1 = stub (done after delay, 0 = never)
  int m_mode  = 0;
  int m_delay = 0;

  gcd_host #(
    .WIDTH   (c_W),
    .TIMEOUT (c_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .gcd_start  (gcd_start),
    .gcd_data   (gcd_data),
    .gcd_rst    (gcd_rst),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_gcd    (rsp_gcd),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- GCD unit model ----------------
  logic [c_W-1:0] m_ra = '0;
  logic [c_W-1:0] m_rb = '0;
  logic           m_done = 1'b0;
  int             m_phase = 0;
  int             m_wcnt = 0;

  always @(posedge clk) begin
    if (gcd_rst) begin
      m_phase <= 0;
      m_done  <= 1'b0;
      m_wcnt  <= 0;
    end else begin
      case (m_phase)
        0: if (gcd_start) m_phase <= 1;
        1: begin m_ra <= gcd_data; m_phase <= 2; end
        2: begin m_rb <= gcd_data; m_phase <= 3; m_wcnt <= 0; end
        default: begin
          if (!m_done) begin
            if (m_mode == 0) begin
              if (m_rb == '0) m_done <= 1'b1;
              else begin
                m_ra <= m_rb;
                m_rb <= m_ra % m_rb;
              end
            end else begin
              m_wcnt <= m_wcnt + 1;
              if (m_delay != 0 && m_wcnt + 1 == m_delay) m_done <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign gcd_done   = m_done;
  assign gcd_result = (m_mode == 0) ? m_ra : c_STUB_RES;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    int             mode;
    int             delay;
    logic [c_W-1:0] exp_gcd;
    logic           exp_err;
    logic           bypass;
    int             exp_wait;   // WAIT cycles before rsp_valid
    int             stall;      // cycles rsp_ready held low
  } vec_t;

  task automatic run_job(input string tag, input vec_t v);
    int cnt;
    m_mode  = v.mode;
    m_delay = v.delay;
    chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
    req_a     = v.a;
    req_b     = v.b;
    req_valid = 1'b1;
    step();                       // accept edge k, now in cycle k+1
    req_valid = 1'b0;
    if (v.bypass) begin
      chk({tag, " byp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " byp_nostart"}, 32'(gcd_start), 32'd0);
    end else begin
      chk({tag, " start"}, {gcd_start, req_ready, gcd_data}, {1'b1, 1'b0, 16'd0});
      step();
      chk({tag, " lda"}, {gcd_start, gcd_data}, {1'b0, v.a});
      step();
      chk({tag, " ldb"}, {gcd_start, gcd_data}, {1'b0, v.b});
      step();
      chk({tag, " wait_data"}, 32'(gcd_data), 32'd0);
      cnt = 0;
      while (!rsp_valid && cnt < 50) begin
        cnt++;
        step();
      end
      chk({tag, " wait_cycles"}, 32'(cnt), 32'(v.exp_wait));
    end
    rsp_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      chk({tag, " stall_hold"}, {rsp_valid, req_ready, rsp_err, rsp_gcd},
          {1'b1, 1'b0, v.exp_err, v.exp_gcd});
      step();
    end
    chk({tag, " rsp"}, {rsp_valid, rsp_err, rsp_gcd}, {1'b1, v.exp_err, v.exp_gcd});
    rsp_ready = 1'b1;
    step();                       // response handshake edge
    rsp_ready = 1'b0;
    if (!v.bypass) begin
      chk({tag, " clr"}, {gcd_rst, req_ready, rsp_valid}, 3'b100);
      step();
      chk({tag, " after_clr"}, {gcd_rst, req_ready}, 2'b01);
    end else begin
      chk({tag, " byp_done"}, {gcd_rst, req_ready, rsp_valid}, 3'b010);
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'd143,   16'd78,    0, 0, 16'd13,    1'b0, 1'b0, 5, 0};
    vecs[1] = '{16'd0,     16'd7,     0, 0, 16'd7,     1'b0, 1'b1, 0, 0};
    vecs[2] = '{16'd0,     16'd0,     0, 0, 16'd0,     1'b0, 1'b1, 0, 0};
    vecs[3] = '{16'd9,     16'd0,     0, 0, 16'd9,     1'b0, 1'b1, 0, 2};
    vecs[4] = '{16'd21,    16'd21,    0, 0, 16'd21,    1'b0, 1'b0, 3, 5};
    vecs[5] = '{16'd5,     16'd3,     1, 0, 16'd0,     1'b1, 1'b0, 8, 0};
    vecs[6] = '{16'd5,     16'd3,     1, 7, c_STUB_RES, 1'b0, 1'b0, 8, 0};
    vecs[7] = '{16'd5,     16'd3,     1, 6, c_STUB_RES, 1'b0, 1'b0, 7, 1};
    vecs[8] = '{16'd48,    16'd18,    0, 0, 16'd6,     1'b0, 1'b0, 5, 0};
    vecs[9] = '{16'hFFFF,  16'hFFFF,  0, 0, 16'hFFFF,  1'b0, 1'b0, 3, 0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    step();
    step();
    chk("reset_outs", {gcd_rst, gcd_start, gcd_data, rsp_valid, rsp_err, rsp_gcd},
        {1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0});
    rst = 1'b0;
    #1;
    chk("reset_release", {gcd_rst, req_ready}, 2'b01);
    step();

    for (int i = 0; i < 10; i++) begin
      run_job($sformatf("v%0d", i), vecs[i]);
      step();
    end

    // reset while waiting on the unit
    m_mode    = 0;
    req_a     = 16'd143;
    req_b     = 16'd78;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();                       // first WAIT cycle
    step();                       // second WAIT cycle
    chk("midrst_in_wait", {rsp_valid, req_ready}, 2'b00);
    rst = 1'b1;
    #1;
    chk("midrst_gcd_rst", 32'(gcd_rst), 32'd1);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_idle", {rsp_valid, req_ready, gcd_rst, gcd_start}, 4'b0100);
    step();
    run_job("after_rst", vecs[8]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop in case the stimulus itself stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_gcd_host
`default_nettype wire
